// File: rtl/meter_pkg.sv
// Shared definitions for the power meter: acquisition states and serial frame layout.
// Frame is OVH, OVL, then ADC_W data bits, MSB first.
package meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_MULT  = 3'd3,
        ST_ACC   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int frame_len(input int adc_w);
        return adc_w + 2;
    endfunction

    // Bit positions inside the received frame register (LSB = last bit shifted in).
    function automatic int ovh_pos(input int adc_w);
        return adc_w + 1;
    endfunction

    function automatic int ovl_pos(input int adc_w);
        return adc_w;
    endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// Shared-clock serial receiver: SCLK divider, chip select, bit counter and one
// shift register per converter lane, all lanes clocked by the same SCLK.
module adc_serial_rx
    import meter_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ADC_W   = 22,
    parameter int CLK_DIV = 4,
    parameter int FRAME   = frame_len(ADC_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold_i,
    input  logic                   go_i,
    input  logic [LANES-1:0]       miso_i,
    output logic                   cs_o,
    output logic                   sclk_o,
    output logic                   frame_done_o,
    output logic [LANES*FRAME-1:0] frame_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

    logic             active_q;
    logic             sclk_q;
    logic             done_q;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_q;
    logic             tick;
    logic             rise;

    assign tick = active_q && (div_q == DIV_LAST);
    assign rise = tick && !sclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (go_i) begin
                active_q <= 1'b1;
                sclk_q   <= 1'b0;
                div_q    <= '0;
                bit_q    <= '0;
            end else if (active_q) begin
                if (tick) begin
                    div_q  <= '0;
                    sclk_q <= ~sclk_q;
                    // Frame ends on the falling edge of the last bit period.
                    if (sclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [FRAME-1:0] sr_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else if (rise) begin
                sr_q <= {sr_q[FRAME-2:0], miso_i[gi]};
            end
        end

        assign frame_o[gi*FRAME +: FRAME] = sr_q;
    end

    assign cs_o         = ~(hold_i | active_q);
    assign sclk_o       = sclk_q;
    assign frame_done_o = done_q;

endmodule

// File: rtl/meter_array.sv
// Multi-channel energy meter: reads NCH voltage/current converter pairs over a shared
// serial bus, multiplies each pair with one shared multiplier and accumulates energy.
module meter_array
    import meter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ADC_W   = 22,
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 65535,
    parameter int ACC_W   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   acc_clr,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [NCH*ADC_W-1:0]   data_v,
    output logic [NCH*ADC_W-1:0]   data_i,
    output logic [NCH*2*ADC_W-1:0] data_p,
    output logic [NCH*ACC_W-1:0]   energy,
    output logic [31:0]            sample_cnt,
    output logic                   adc_cs_pin,
    output logic                   adc_sclk_pin,
    input  logic [NCH-1:0]         v_miso_pin,
    input  logic [NCH-1:0]         i_miso_pin
);

    localparam int FRAME   = frame_len(ADC_W);
    localparam int LANES   = 2 * NCH;
    localparam int OVH_BIT = ovh_pos(ADC_W);
    localparam int OVL_BIT = ovl_pos(ADC_W);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int P_W     = 2 * ADC_W;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    state_t                        state_q, state_d;
    logic [TMO_W-1:0]              conv_cnt_q;
    logic                          rdy_q;
    logic                          tmo_q;
    logic [IDX_W-1:0]              idx_q;
    logic [31:0]                   cnt_q;
    logic [NCH-1:0][P_W-1:0]       pstage_q;
    logic [NCH-1:0][ADC_W-1:0]     v_samp;
    logic [NCH-1:0][ADC_W-1:0]     i_samp;
    logic signed [ADC_W-1:0]       mv, mi;
    logic signed [P_W-1:0]         prod;
    logic [LANES*FRAME-1:0]        frame;
    logic                          all_zero;
    logic                          go;
    logic                          timeout_hit;
    logic                          frame_done;
    logic                          shift_hold;

    function automatic logic [ADC_W-1:0] sat_decode(input logic [FRAME-1:0] f);
        if (f[OVH_BIT]) return {1'b0, {(ADC_W-1){1'b1}}};
        if (f[OVL_BIT]) return {1'b1, {(ADC_W-1){1'b0}}};
        return f[ADC_W-1:0];
    endfunction

    assign all_zero   = ~|{i_miso_pin, v_miso_pin};
    assign shift_hold = (state_q == ST_CONV) || (state_q == ST_SHIFT);

    adc_serial_rx #(
        .LANES   (LANES),
        .ADC_W   (ADC_W),
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .hold_i       (shift_hold),
        .go_i         (go),
        .miso_i       ({i_miso_pin, v_miso_pin}),
        .cs_o         (adc_cs_pin),
        .sclk_o       (adc_sclk_pin),
        .frame_done_o (frame_done),
        .frame_o      (frame)
    );

    always_comb begin
        state_d     = state_q;
        go          = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start || continuous) state_d = ST_CONV;
            ST_CONV: begin
                // Ready wins over a timeout landing in the same cycle.
                if (all_zero && rdy_q) begin
                    state_d = ST_SHIFT;
                    go      = 1'b1;
                end else if (conv_cnt_q == TMO_LAST) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_SHIFT: if (frame_done) state_d = ST_MULT;
            ST_MULT:  if (idx_q == IDX_LAST) state_d = ST_ACC;
            ST_ACC:   state_d = ST_DONE;
            ST_DONE:  state_d = continuous ? ST_CONV : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // One shared multiplier walks the channels, one per clock.
    assign mv   = v_samp[idx_q];
    assign mi   = i_samp[idx_q];
    assign prod = P_W'(mv) * P_W'(mi);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
            rdy_q      <= 1'b0;
            tmo_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            pstage_q   <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= (state_q == ST_CONV) && all_zero;
            conv_cnt_q <= (state_q == ST_CONV) ? conv_cnt_q + 1'b1 : '0;
            idx_q      <= (state_q == ST_MULT) ? idx_q + 1'b1 : '0;
            if (state_q == ST_MULT) pstage_q[idx_q] <= prod;
            if (state_q == ST_IDLE && start) tmo_q <= 1'b0;
            else if (timeout_hit)            tmo_q <= 1'b1;
            if (acc_clr)                                cnt_q <= '0;
            else if (state_q == ST_ACC && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [ADC_W-1:0] dv_q, di_q;
        logic [P_W-1:0]   dp_q;
        logic [ACC_W-1:0] en_q;

        assign v_samp[gi] = sat_decode(frame[gi*FRAME +: FRAME]);
        assign i_samp[gi] = sat_decode(frame[(NCH+gi)*FRAME +: FRAME]);

        // Published results change only in ACC so a reader never sees a half-updated set.
        always_ff @(posedge clk) begin
            if (rst) begin
                dv_q <= '0;
                di_q <= '0;
                dp_q <= '0;
                en_q <= '0;
            end else begin
                if (state_q == ST_ACC) begin
                    dv_q <= v_samp[gi];
                    di_q <= i_samp[gi];
                    dp_q <= pstage_q[gi];
                end
                if (acc_clr)                en_q <= '0;
                else if (state_q == ST_ACC) en_q <= en_q + ACC_W'($signed(pstage_q[gi]));
            end
        end

        assign data_v[gi*ADC_W +: ADC_W] = dv_q;
        assign data_i[gi*ADC_W +: ADC_W] = di_q;
        assign data_p[gi*P_W +: P_W]     = dp_q;
        assign energy[gi*ACC_W +: ACC_W] = en_q;
    end

    assign busy        = (state_q == ST_CONV) || (state_q == ST_SHIFT) ||
                         (state_q == ST_MULT) || (state_q == ST_ACC);
    assign done        = (state_q == ST_DONE);
    assign timeout_err = tmo_q;
    assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_meter_array.sv
// Directed bench for meter_array with behavioural converter models on every miso lane.
module tb_meter_array;

    localparam int NCH = 2;
    localparam int W   = 22;
    localparam int AW  = 64;

    logic clk = 1'b0;
    logic rst, start, continuous, acc_clr;
    logic busy, done, timeout_err;
    logic [NCH*W-1:0]   data_v, data_i;
    logic [NCH*2*W-1:0] data_p;
    logic [NCH*AW-1:0]  energy;
    logic [31:0]        sample_cnt;
    logic               adc_cs_pin, adc_sclk_pin;
    logic [NCH-1:0]     v_miso_pin, i_miso_pin;

    always #5 clk = ~clk;

    meter_array #(
        .NCH(NCH), .ADC_W(W), .CLK_DIV(4), .TIMEOUT(100), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .acc_clr(acc_clr),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .data_v(data_v), .data_i(data_i), .data_p(data_p), .energy(energy),
        .sample_cnt(sample_cnt), .adc_cs_pin(adc_cs_pin), .adc_sclk_pin(adc_sclk_pin),
        .v_miso_pin(v_miso_pin), .i_miso_pin(i_miso_pin)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Converter model: busy (1) for 3 clocks after cs falls, ready (0) for 2, then frame bits
    // advanced on every rising sclk so the next bit is stable before the next rise.
    logic [23:0] vf [2];
    logic [23:0] ifr [2];
    logic [3:0]  stuck;
    int          mcnt = 0;
    int          mbit = 0;
    logic        prev_sclk = 1'b0;

    function automatic logic fbit(input logic [23:0] f, input int cnt, input int nb);
        logic [23:0] t;
        t = f;
        if (cnt <= 3) return 1'b1;
        if (cnt <= 5) return 1'b0;
        if (nb >= 24) return 1'b0;
        return t[23-nb];
    endfunction

    always @(negedge clk) begin
        if (adc_cs_pin !== 1'b0) begin
            mcnt = 0;
            mbit = 0;
            prev_sclk = 1'b0;
        end else begin
            mcnt++;
            if (adc_sclk_pin && !prev_sclk) mbit++;
            prev_sclk = adc_sclk_pin;
        end
        for (int l = 0; l < 2; l++) begin
            v_miso_pin[l] = ((adc_cs_pin !== 1'b0) ? 1'b1 : fbit(vf[l], mcnt, mbit)) | stuck[l];
            i_miso_pin[l] = ((adc_cs_pin !== 1'b0) ? 1'b1 : fbit(ifr[l], mcnt, mbit)) | stuck[2+l];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
        $display("check %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    function automatic logic [63:0] vget(input int k);
        logic signed [W-1:0] t;
        t = data_v[k*W +: W];
        return 64'(t);
    endfunction

    function automatic logic [63:0] iget(input int k);
        logic signed [W-1:0] t;
        t = data_i[k*W +: W];
        return 64'(t);
    endfunction

    function automatic logic [63:0] pget(input int k);
        logic signed [2*W-1:0] t;
        t = data_p[k*2*W +: 2*W];
        return 64'(t);
    endfunction

    function automatic logic [63:0] eget(input int k);
        return energy[k*AW +: AW];
    endfunction

    function automatic logic [23:0] mkf(input logic ovh, input logic ovl, input int val);
        logic [W-1:0] d;
        d = W'(val);
        return {ovh, ovl, d};
    endfunction

    task automatic set_all(input int v, input int i);
        for (int k = 0; k < 2; k++) begin
            vf[k]  = mkf(1'b0, 1'b0, v);
            ifr[k] = mkf(1'b0, 1'b0, i);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 64'(done_cnt), 64'(target));
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; acc_clr = 1'b0;
        stuck = 4'b0000;
        set_all(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(adc_cs_pin), 64'sd1);
        chk("rst_sclk", 64'(adc_sclk_pin), 64'sd0);
        chk("rst_busy", 64'(busy), 64'sd0);
        chk("rst_done", 64'(done), 64'sd0);
        chk("rst_tmo", 64'(timeout_err), 64'sd0);
        chk("rst_cnt", 64'(sample_cnt), 64'sd0);
        chk("rst_e0", eget(0), 64'sd0);
        chk("rst_p0", pget(0), 64'sd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic acquisition, plus a start pulse mid-acquisition that must be ignored
        set_all(1000, -3);
        pulse_start();
        chk("A_busy", 64'(busy), 64'sd1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(1, "A_done");
        @(negedge clk);
        chk("A_v0", vget(0), 64'sd1000);
        chk("A_i1", iget(1), -64'sd3);
        chk("A_p0", pget(0), -64'sd3000);
        chk("A_p1", pget(1), -64'sd3000);
        chk("A_e0", eget(0), -64'sd3000);
        chk("A_e1", eget(1), -64'sd3000);
        chk("A_cnt", 64'(sample_cnt), 64'sd1);
        repeat (300) @(negedge clk);
        chk("A_one_done", 64'(done_cnt), 64'sd1);
        chk("A_cnt_after", 64'(sample_cnt), 64'sd1);
        chk("A_idle_cs", 64'(adc_cs_pin), 64'sd1);

        // Overrange saturation and full-width products
        vf[0]  = mkf(1'b1, 1'b0, 5);
        vf[1]  = mkf(1'b0, 1'b0, 1000);
        ifr[0] = mkf(1'b1, 1'b0, 0);
        ifr[1] = mkf(1'b0, 1'b1, 12345);
        pulse_start();
        wait_dones(2, "B_done");
        @(negedge clk);
        chk("B_v0", vget(0), 64'sd2097151);
        chk("B_i1", iget(1), -64'sd2097152);
        chk("B_p0", pget(0), 64'sd4398042316801);
        chk("B_p1", pget(1), -64'sd2097152000);
        chk("B_e0", eget(0), 64'sd4398042313801);
        chk("B_e1", eget(1), -64'sd2097155000);
        chk("B_cnt", 64'(sample_cnt), 64'sd2);

        // Ready timeout with one current lane stuck high
        stuck = 4'b1000;
        pulse_start();
        repeat (99) @(negedge clk);
        chk("C_tmo_early", 64'(timeout_err), 64'sd0);
        chk("C_busy_early", 64'(busy), 64'sd1);
        @(negedge clk);
        chk("C_tmo", 64'(timeout_err), 64'sd1);
        chk("C_cs", 64'(adc_cs_pin), 64'sd1);
        chk("C_busy", 64'(busy), 64'sd0);
        chk("C_cnt", 64'(sample_cnt), 64'sd2);
        chk("C_v0", vget(0), 64'sd2097151);
        chk("C_no_done", 64'(done_cnt), 64'sd2);
        stuck = 4'b0000;

        // Continuous mode: three acquisitions, dropped during the third
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("D_clr_e0", eget(0), 64'sd0);
        chk("D_clr_cnt", 64'(sample_cnt), 64'sd0);
        set_all(2, 5);
        continuous = 1'b1;
        wait_dones(4, "D_done2");
        repeat (20) @(negedge clk);
        continuous = 1'b0;
        wait_dones(5, "D_done3");
        repeat (300) @(negedge clk);
        chk("D_done_total", 64'(done_cnt), 64'sd5);
        chk("D_e0", eget(0), 64'sd30);
        chk("D_e1", eget(1), 64'sd30);
        chk("D_cnt", 64'(sample_cnt), 64'sd3);
        chk("D_p1", pget(1), 64'sd10);
        chk("D_busy", 64'(busy), 64'sd0);
        chk("D_tmo_kept", 64'(timeout_err), 64'sd1);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("D_clr2_e0", eget(0), 64'sd0);
        chk("D_clr2_e1", eget(1), 64'sd0);
        chk("D_clr2_cnt", 64'(sample_cnt), 64'sd0);

        // Reset in the middle of the serial frame, then a clean acquisition
        set_all(7, 9);
        pulse_start();
        chk("E_tmo_clr", 64'(timeout_err), 64'sd0);
        repeat (88) @(negedge clk);
        chk("E_midframe_cs", 64'(adc_cs_pin), 64'sd0);
        rst = 1'b1;
        @(negedge clk);
        chk("E_cs", 64'(adc_cs_pin), 64'sd1);
        chk("E_sclk", 64'(adc_sclk_pin), 64'sd0);
        chk("E_busy", 64'(busy), 64'sd0);
        chk("E_v0", vget(0), 64'sd0);
        chk("E_i0", iget(0), 64'sd0);
        chk("E_p0", pget(0), 64'sd0);
        rst = 1'b0;
        set_all(1000, -3);
        pulse_start();
        wait_dones(6, "E_done");
        @(negedge clk);
        chk("E_e0", eget(0), -64'sd3000);
        chk("E_p1", pget(1), -64'sd3000);
        chk("E_cnt", 64'(sample_cnt), 64'sd1);

        // acc_clr landing exactly in the ACC cycle
        set_all(2, 5);
        pulse_start();
        cyc = 0;
        while (!(adc_cs_pin === 1'b1 && busy === 1'b1) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("F_mult_seen", 64'(adc_cs_pin & busy), 64'sd1);
        @(negedge clk);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("F_done_align", 64'(done), 64'sd1);
        chk("F_e0", eget(0), 64'sd0);
        chk("F_e1", eget(1), 64'sd0);
        chk("F_cnt", 64'(sample_cnt), 64'sd0);
        chk("F_p0", pget(0), 64'sd10);
        chk("F_v0", vget(0), 64'sd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
